// File: rtl/types.sv
// types: shared arbiter state encoding and default widths for cache_arbiter
package types;
    localparam int LINE_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one pmem port between icache and dcache; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module cache_arbiter
    import types::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    arb_state_t state, state_n;
    logic [LINE_W-1:0] line_q;
    logic i_req, d_req, grant_d, serving;
    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read || d_pmem_write;
    assign serving = state == SERVE_I || state == SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign grant_d = d_req && !(i_req && last_d);
`else
    assign grant_d = d_req;
`endif
    assign i_pmem_rdata = line_q;
    assign d_pmem_rdata = line_q;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (grant_d ? SERVE_D : i_req ? SERVE_I : IDLE)
                : state == DONE ? IDLE
                : mem_resp ? DONE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            line_q      <= '0;
            i_pmem_resp <= 1'b0;
            d_pmem_resp <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            i_pmem_resp <= 1'b0;
            d_pmem_resp <= 1'b0;
            if (state == IDLE && (d_req || i_req)) begin
                mem_address <= grant_d ? d_pmem_address : i_pmem_address;
                mem_wdata   <= d_pmem_wdata;
                mem_write   <= grant_d && d_pmem_write;
                mem_read    <= !(grant_d && d_pmem_write);
`ifdef ARB_ROUND_ROBIN_EN
                last_d      <= grant_d;
`endif
            end
            if (serving && mem_resp) begin
                line_q      <= mem_rdata;
                mem_read    <= 1'b0;
                mem_write   <= 1'b0;
                i_pmem_resp <= state == SERVE_I;
                d_pmem_resp <= state == SERVE_D;
            end
        end
    end
    // write-back wins if both are raised, but a well-behaved dcache never does that
    a_no_dual_d: assert property (@(posedge clk) disable iff (!rst) !(d_pmem_read && d_pmem_write));
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Multi-cycle arbiter that shares the single physical-memory port (through the cacheline adaptor) between the instruction cache and the data cache of the pipelined RV32I core. Requests are granted one at a time. Address and write data are latched at grant. The returned line is registered and handed back with a one-cycle response pulse. The block sits between the two caches' pmem-side ports and the cacheline adaptor.

## Interface
- LINE_W, 256: cache line width in bits
- ADDR_W, 32: physical address width
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache line address, 32-byte aligned
- i_pmem_rdata  out  LINE_W  line returned to icache
- i_pmem_resp  out  1  icache completion pulse
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache write-back request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache write-back line
- d_pmem_rdata  out  LINE_W  line returned to dcache
- d_pmem_resp  out  1  dcache completion pulse
- mem_read, mem_write  out  1 each  adaptor commands
- mem_address  out  ADDR_W  adaptor address
- mem_wdata  out  LINE_W  adaptor write line
- mem_rdata  in  LINE_W  adaptor read line
- mem_resp  in  1  adaptor completion, one-cycle pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - d request (read or write) → SERVE_D.
  - else i request → SERVE_I.
  - else stay in IDLE.
  - On grant, latch address, wdata, and direction (read/write).
- SERVE_x:
  - Drive mem_read or mem_write from the latched direction, held constant until mem_resp.
  - mem_address and mem_wdata come from the latch registers.
  - On mem_resp: capture mem_rdata into the line register, go to DONE, drop mem_read/mem_write that same edge.
- DONE: assert the granted requester's resp for exactly one cycle, then go to IDLE.
- rdata outputs hold the last captured line; both outputs see the same register, and only the resp pulse is steered.
- If d_pmem_read and d_pmem_write are both high, write-back is served first. Requesters never do this; the condition is flagged by an assertion.
- Requesters hold request and address stable until their resp. They deassert in the cycle after resp. A request still high in IDLE after DONE is treated as new.
- Simultaneous i and d requests in IDLE: the d request wins, and i waits in IDLE until the next pass.
- Reset values: state=IDLE; all mem_* commands 0; mem_address, mem_wdata, line register, and both resp outputs 0.
- Reset mid-transaction: return to IDLE next edge and drop commands. The adaptor treats the abandoned transaction as cancelled. A mem_resp in the cycle after reset is ignored.
- mem_resp arriving in IDLE or DONE is ignored.

## Timing
- Request seen high at edge N (IDLE) → mem command high from cycle N+1.
- mem_resp high in cycle M → x_pmem_resp and valid rdata in cycle M+1; IDLE at M+2.
- Minimum occupancy with a 1-cycle adaptor: 3 cycles per transaction. Back-to-back grants are separated by DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests in IDLE are granted to the side not served last. The last_served flop resets to i, so d wins the first tie.
  - Single requests are granted immediately regardless.
- ARB_ROUND_ROBIN_EN undefined: fixed dcache priority, as in Operation.

## Structure
- arb_state_t enum (IDLE, SERVE_I, SERVE_D, DONE) and the LINE_W default go in the shared `types` package.
- Single module, no sub-module: the grant logic is a few lines of the next-state block.

## Test plan
- Reset hold 2 cycles with garbage inputs → all outputs 0, state IDLE.
- i read to 0x0000_0060, adaptor resp after 4 cycles with line 0xA5…A5 → mem_read for 4 cycles, i_pmem_resp one cycle, i_pmem_rdata=0xA5…A5, d_pmem_resp never.
- d write to 0x0000_1000, wdata 0x1234…, plus simultaneous i read → d served first (mem_write, mem_wdata correct), then i read granted after DONE.
- i and d reads together, twice in succession, with ARB_ROUND_ROBIN_EN → grants d, i, then d, i; without the macro → d, i, d, i (d first each tie).
- rst low during SERVE_D, mem_resp arriving the next cycle → IDLE, no resp pulse, mem_read=0.
- Stray mem_resp in IDLE → no state change, no resp pulse.
